// File: rtl/fir_tap_line.sv
// ----------------------------------------------------------------------------
// fir_tap_line
// Delay line for a 10-coefficient FIR. Accepted samples shift into x0 and age
// toward x9. Each tap drives the address of one coefficient memory (h0..h9).
// tap_valid marks a complete window on the taps. prod_valid is tap_valid
// delayed by one cycle, which lines it up with the registered memory outputs.
// A flush request drains a full window by shifting in zeros, or discards a
// partial window.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : incoming unsigned sample (DW bits)
//   in_valid   : in_data is valid this cycle
//   in_ready   : block accepts a sample this cycle
//   flush      : single-cycle drain/discard request
//   x0..x9     : registered taps, x0 newest, x9 oldest
//   tap_valid  : taps hold a complete window produced by the preceding edge
//   prod_valid : tap_valid delayed by one cycle
//   fill_cnt   : number of valid samples held, 0..TAPS
//   busy       : state is not EMPTY
//
// State table
//   state  | meaning
//   EMPTY  | no samples held, waiting for the first accept
//   FILL   | 1..TAPS-1 samples held, no complete window yet
//   RUN    | full window held, every accept produces a window
//   FLUSH  | shifting zeros out of a full window, inputs ignored
// ----------------------------------------------------------------------------
module fir_tap_line #(
    parameter int TAPS = 10,
    parameter int DW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic [DW-1:0] x0,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] x2,
    output logic [DW-1:0] x3,
    output logic [DW-1:0] x4,
    output logic [DW-1:0] x5,
    output logic [DW-1:0] x6,
    output logic [DW-1:0] x7,
    output logic [DW-1:0] x8,
    output logic [DW-1:0] x9,
    output logic          tap_valid,
    output logic          prod_valid,
    output logic [3:0]    fill_cnt,
    output logic          busy
);

    localparam int         NOUT     = 10;
    localparam logic [3:0] TAPS_CNT = 4'(TAPS);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] taps_q [TAPS];
    logic [DW-1:0] taps_d [TAPS];
    logic [3:0]    fill_q, fill_d;
    logic          tap_valid_q, tap_valid_d;
    logic          prod_valid_q;

    logic          accept;
    logic          do_shift;
    logic          do_clear;
    logic [DW-1:0] shift_in;

    assign in_ready = (state_q != S_FLUSH) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        tap_valid_d = 1'b0;
        do_shift    = 1'b0;
        do_clear    = 1'b0;
        shift_in    = in_data;

        case (state_q)
            S_EMPTY: begin
                // flush is ignored here; accept is already masked by it
                if (accept) begin
                    do_shift = 1'b1;
                    fill_d   = 4'd1;
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                if (flush) begin
                    do_clear = 1'b1;
                    fill_d   = 4'd0;
                    state_d  = S_EMPTY;
                end else if (accept) begin
                    do_shift = 1'b1;
                    fill_d   = fill_q + 4'd1;
                    // the accept completing the window already yields a window
                    if (fill_q == TAPS_CNT - 4'd1) begin
                        state_d     = S_RUN;
                        tap_valid_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (accept) begin
                    do_shift    = 1'b1;
                    tap_valid_d = 1'b1;
                end
            end
            S_FLUSH: begin
                // fill_cnt doubles as the drain down-counter: TAPS-1 zero
                // shifts take it from TAPS down to 1, then the line is cleared
                if (fill_q > 4'd1) begin
                    do_shift    = 1'b1;
                    shift_in    = '0;
                    fill_d      = fill_q - 4'd1;
                    tap_valid_d = 1'b1;
                end else begin
                    do_clear = 1'b1;
                    fill_d   = 4'd0;
                    state_d  = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_comb begin
        taps_d = taps_q;
        if (do_clear) begin
            for (int i = 0; i < TAPS; i++) begin
                taps_d[i] = '0;
            end
        end else if (do_shift) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                taps_d[i] = taps_q[i-1];
            end
            taps_d[0] = shift_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            fill_q       <= 4'd0;
            tap_valid_q  <= 1'b0;
            prod_valid_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            tap_valid_q  <= tap_valid_d;
            prod_valid_q <= tap_valid_q;
            for (int i = 0; i < TAPS; i++) begin
                taps_q[i] <= taps_d[i];
            end
        end
    end

    // Fixed set of ten memory address outputs; taps beyond TAPS read as zero.
    logic [DW-1:0] x_out [NOUT];

    for (genvar g = 0; g < NOUT; g++) begin : g_out
        if (g < TAPS) begin : g_tap
            assign x_out[g] = taps_q[g];
        end else begin : g_zero
            assign x_out[g] = '0;
        end
    end

    assign x0 = x_out[0];
    assign x1 = x_out[1];
    assign x2 = x_out[2];
    assign x3 = x_out[3];
    assign x4 = x_out[4];
    assign x5 = x_out[5];
    assign x6 = x_out[6];
    assign x7 = x_out[7];
    assign x8 = x_out[8];
    assign x9 = x_out[9];

    assign tap_valid  = tap_valid_q;
    assign prod_valid = prod_valid_q;
    assign fill_cnt   = fill_q;
    assign busy       = (state_q != S_EMPTY);

endmodule
